// File: rtl/uart_pkg.sv
// Shared constants, framer state type and escape helper for the uart tx framer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

  localparam logic [7:0] ESC_BYTE    = 8'h7D;
  localparam logic [7:0] ESC_XOR     = 8'h20;
  localparam logic [7:0] DEFAULT_SOF = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    LEN,
    DATA,
    ESC,
    CSUM
  } framer_state_t;

  // True for the two byte values that must be stuffed on the wire.
  function automatic logic needs_esc(input logic [7:0] b);
    return (b == DEFAULT_SOF) || (b == ESC_BYTE);
  endfunction

endpackage

// File: rtl/uart_payload_buf.sv
// Payload staging buffer: linear byte store filled from index 0, read at rd_idx.
// Latency: write visible at rd_data the cycle after wr; count/full registered.
// Backpressure: caller must not write when full; clr empties the buffer in one cycle.
module uart_payload_buf #(
  parameter int unsigned MAX_LEN = 16,
  localparam int CW = $clog2(MAX_LEN + 1),
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [7:0]    wr_data,
  input  logic          clr,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [7:0] mem [MAX_LEN];

  // Byte store; contents need no reset because count gates what is valid.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[count[IW-1:0]] <= wr_data;
    end
  end

  // Fill level and registered full flag; clear wins over write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      full  <= 1'b0;
    end else if (wr) begin
      count <= count + 1'b1;
      full  <= (count + 1'b1) == CW'(MAX_LEN);
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_tx_framer.sv
// Frames buffered payload as SOF,LEN,payload,CSUM into the uart TX FIFO; optional byte stuffing via UART_TX_FRAMER_ESC_EN.
// Latency: send at edge N gives tx_start with SOF after edge N+1; at most one byte every 2 cycles.
// Backpressure: no byte issued while tx_full=1; one idle gap after every issue so tx_full can catch up.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter logic [7:0]  SOF_BYTE = DEFAULT_SOF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pl_wr,
  input  logic [7:0] pl_data,
  output logic       pl_full,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_full
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  framer_state_t state_q, state_d;
  framer_state_t ret_q, ret_d;
  framer_state_t after;
  logic          gap_q;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    esc_q, esc_d;
  logic [7:0]    raw_byte, byte_out;
  logic [7:0]    rd_data;
  logic [CW-1:0] count;
  logic          issue, buf_clr, wr_ok, send_ok, last_data;

  // Writes only land while idle and not full; a same-cycle write makes an empty buffer sendable.
  assign wr_ok     = pl_wr && (state_q == IDLE) && !pl_full;
  assign send_ok   = send && (state_q == IDLE) && ((count != '0) || wr_ok);
  assign last_data = (CW'(rd_idx_q) + CW'(1)) == count;

  uart_payload_buf #(
    .MAX_LEN(MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr_ok),
    .wr_data (pl_data),
    .clr     (buf_clr),
    .rd_idx  (rd_idx_q),
    .rd_data (rd_data),
    .count   (count),
    .full    (pl_full)
  );

  // Next-state, byte selection, checksum accumulation and issue decision.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    rd_idx_d = rd_idx_q;
    sum_d    = sum_q;
    esc_d    = esc_q;
    raw_byte = 8'h00;
    after    = IDLE;
    byte_out = 8'h00;
    issue    = 1'b0;
    buf_clr  = 1'b0;

    case (state_q)
      SOF:  begin raw_byte = SOF_BYTE;        after = LEN;  end
      LEN:  begin raw_byte = 8'(count);       after = DATA; end
      DATA: begin raw_byte = rd_data;         after = last_data ? CSUM : DATA; end
      CSUM: begin raw_byte = 8'h00 - sum_q;   after = IDLE; end
      ESC:  begin raw_byte = esc_q;           after = ret_q; end
      default: begin raw_byte = 8'h00;        after = IDLE; end
    endcase

    if (state_q == IDLE) begin
      if (send_ok) begin
        state_d  = SOF;
        rd_idx_d = '0;
      end
    end else if (!tx_full && !gap_q) begin
      issue    = 1'b1;
      byte_out = raw_byte;
      state_d  = after;
      // The checksum runs over unescaped LEN and payload values.
      case (state_q)
        LEN:  sum_d = raw_byte;
        DATA: begin
          sum_d    = sum_q + raw_byte;
          rd_idx_d = rd_idx_q + 1'b1;
        end
        default: sum_d = sum_q;
      endcase
`ifdef UART_TX_FRAMER_ESC_EN
      // Stuff LEN/payload/CSUM specials: send ESC now, the xored byte from the ESC sub-state.
      if ((state_q != SOF) && (state_q != ESC) && needs_esc(raw_byte)) begin
        byte_out = ESC_BYTE;
        esc_d    = raw_byte ^ ESC_XOR;
        ret_d    = after;
        state_d  = ESC;
      end
`endif
      buf_clr = (state_d == IDLE);
    end
  end

  // State and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ret_q    <= IDLE;
      gap_q    <= 1'b0;
      rd_idx_q <= '0;
      sum_q    <= 8'h00;
      esc_q    <= 8'h00;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      gap_q    <= issue;
      rd_idx_q <= rd_idx_d;
      sum_q    <= sum_d;
      esc_q    <= esc_d;
      tx_start <= issue;
      tx_data  <= issue ? byte_out : tx_data;
      busy     <= (state_d != IDLE);
      done     <= issue && (state_d == IDLE);
      err      <= (pl_wr && !wr_ok) || (send && !send_ok);
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomised self-checking bench for uart_tx_framer against a frame-level reference model.
// Latency: checks SOF one cycle after send and a 2-cycle issue spacing.
// Backpressure: drives tx_full stalls and flags any issue after a full sample.
module tb_uart_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pl_wr = 1'b0;
  logic [7:0] pl_data = 8'h00;
  logic       pl_full;
  logic       send = 1'b0;
  logic       busy, done, err, tx_start;
  logic [7:0] tx_data;
  logic       tx_full = 1'b0;

  int passed = 0;
  int total  = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         last_cyc = -10;
  int         viol = 0;
  int         done_cnt = 0;
  logic       full_s = 1'b0;

  uart_tx_framer #(.MAX_LEN(16), .SOF_BYTE(8'h7E)) dut (
    .clk(clk), .rst(rst), .pl_wr(pl_wr), .pl_data(pl_data), .pl_full(pl_full),
    .send(send), .busy(busy), .done(done), .err(err),
    .tx_start(tx_start), .tx_data(tx_data), .tx_full(tx_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    full_s <= tx_full;
  end

  // Capture issued bytes; flag issues after a full sample or closer than 2 cycles apart.
  always @(negedge clk) begin
    if (tx_start) begin
      got.push_back(tx_data);
      got_cyc.push_back(cyc);
      if (full_s) viol++;
      if (cyc - last_cyc < 2) viol++;
      last_cyc = cyc;
    end
    if (done) done_cnt++;
  end

  // Reference frame built straight from the framing rules.
  function automatic bq_t build_frame(input bq_t pl);
    bq_t f;
    bq_t b;
    logic [7:0] s;
    s = 8'(pl.size());
    b.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      b.push_back(pl[i]);
      s = s + pl[i];
    end
    b.push_back(8'h00 - s);
    f.push_back(8'h7E);
    foreach (b[i]) begin
`ifdef UART_TX_FRAMER_ESC_EN
      if (b[i] == 8'h7E || b[i] == 8'h7D) begin
        f.push_back(8'h7D);
        f.push_back(b[i] ^ 8'h20);
      end else
`endif
        f.push_back(b[i]);
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    pl_wr = 1'b1;
    pl_data = b;
    tick();
    pl_wr = 1'b0;
  endtask

  task automatic do_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit stall, output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
      tx_full = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
    end
    tx_full = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (pl_full !== 1'b0) $display("FAIL reset_pl_full: got %b expected 0", pl_full); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
    total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b expected 0", tx_start); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %02h expected 00", tx_data); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bq_t pl, exp;
    bit ok;
    int d0;
    pl = '{8'hA5, 8'h5A, 8'h3C};
    exp = build_frame(pl);
    got.delete(); got_cyc.delete();
    d0 = done_cnt;
    foreach (pl[i]) write_byte(pl[i]);
    do_send();
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'h7E)
      $display("FAIL basic_latency: got start=%b data=%02h expected start=1 data=7E", tx_start, tx_data);
    else passed++;
    wait_done(200, 1'b0, ok);
    total++; if (!ok) $display("FAIL basic_done_timeout: got no done expected done"); else passed++;
    total++; if (got.size() != 6) $display("FAIL basic_len: got %0d bytes expected 6", got.size()); else passed++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) $display("FAIL basic_byte[%0d]: got %02h expected %02h", i, got[i], exp[i]);
      else passed++;
    end
    total++; if (exp[5] !== 8'hC2 || got.size() < 6 || got[5] !== 8'hC2) $display("FAIL basic_csum: got %02h expected C2", got.size() > 5 ? got[5] : 8'hxx); else passed++;
    for (int i = 1; i < got_cyc.size(); i++) begin
      total++;
      if (got_cyc[i] - got_cyc[i-1] != 2) $display("FAIL basic_spacing[%0d]: got %0d expected 2", i, got_cyc[i] - got_cyc[i-1]);
      else passed++;
    end
    total++; if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", busy); else passed++;
    total++; if (pl_full !== 1'b0) $display("FAIL basic_pl_full_after: got %b expected 0", pl_full); else passed++;
  endtask

  task automatic test_backpressure();
    bq_t pl, exp;
    bit ok;
    int seen;
    pl = '{8'h01, 8'h02, 8'h03};
    exp = build_frame(pl);
    got.delete();
    foreach (pl[i]) write_byte(pl[i]);
    do_send();
    for (int i = 0; i < 20; i++) begin
      if (tx_start) break;
      tick();
    end
    total++; if (tx_start !== 1'b1 || tx_data !== 8'h7E) $display("FAIL bp_sof: got start=%b data=%02h expected start=1 data=7E", tx_start, tx_data); else passed++;
    tx_full = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start) seen++;
    end
    total++; if (seen != 0) $display("FAIL bp_stalled_starts: got %0d expected 0", seen); else passed++;
    tx_full = 1'b0;
    wait_done(200, 1'b0, ok);
    total++; if (!ok) $display("FAIL bp_done_timeout: got no done expected done"); else passed++;
    total++; if (got.size() != exp.size()) $display("FAIL bp_len: got %0d expected %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) $display("FAIL bp_byte[%0d]: got %02h expected %02h", i, got[i], exp[i]);
      else passed++;
    end
    total++; if (viol != 0) $display("FAIL bp_issue_rule: got %0d violations expected 0", viol); else passed++;
  endtask

  task automatic test_errors();
    bq_t pl, exp;
    bit ok;
    int seen;
    got.delete();
    do_send();
    total++; if (err !== 1'b1) $display("FAIL err_empty_send: got %b expected 1", err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL err_empty_busy: got %b expected 0", busy); else passed++;
    tick();
    total++; if (err !== 1'b0) $display("FAIL err_pulse_width: got %b expected 0", err); else passed++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (tx_start) seen++;
      tick();
    end
    total++; if (seen != 0 || got.size() != 0) $display("FAIL err_empty_no_tx: got %0d starts expected 0", seen + got.size()); else passed++;
    pl.push_back(8'($urandom));
    pl.push_back(8'($urandom));
    exp = build_frame(pl);
    foreach (pl[i]) write_byte(pl[i]);
    do_send();
    tick(); tick();
    total++; if (busy !== 1'b1) $display("FAIL err_busy_during: got %b expected 1", busy); else passed++;
    do_send();
    total++; if (err !== 1'b1) $display("FAIL err_busy_send: got %b expected 1", err); else passed++;
    wait_done(200, 1'b0, ok);
    total++; if (!ok) $display("FAIL err_done_timeout: got no done expected done"); else passed++;
    total++; if (got.size() != exp.size()) $display("FAIL err_frame_len: got %0d expected %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) $display("FAIL err_byte[%0d]: got %02h expected %02h", i, got[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    bq_t pl, exp;
    bit ok;
    got.delete();
    for (int i = 0; i < 16; i++) begin
      pl.push_back(8'($urandom));
      write_byte(pl[i]);
      if (i == 14) begin
        total++; if (pl_full !== 1'b0) $display("FAIL ovf_not_full_15: got %b expected 0", pl_full); else passed++;
      end
    end
    total++; if (pl_full !== 1'b1) $display("FAIL ovf_full_16: got %b expected 1", pl_full); else passed++;
    total++; if (err !== 1'b0) $display("FAIL ovf_err_16: got %b expected 0", err); else passed++;
    write_byte(8'($urandom));
    total++; if (err !== 1'b1) $display("FAIL ovf_err_17: got %b expected 1", err); else passed++;
    exp = build_frame(pl);
    do_send();
    wait_done(400, 1'b0, ok);
    total++; if (!ok) $display("FAIL ovf_done_timeout: got no done expected done"); else passed++;
    total++; if (got.size() < 2 || got[1] !== 8'h10) $display("FAIL ovf_len_byte: got %02h expected 10", got.size() > 1 ? got[1] : 8'hxx); else passed++;
    total++; if (got.size() != exp.size()) $display("FAIL ovf_frame_len: got %0d expected %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) $display("FAIL ovf_byte[%0d]: got %02h expected %02h", i, got[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_escape();
    bq_t pl, exp;
    bit ok;
    got.delete();
    pl = '{8'h7E, 8'h7D};
`ifdef UART_TX_FRAMER_ESC_EN
    exp = '{8'h7E, 8'h02, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h03};
`else
    exp = '{8'h7E, 8'h02, 8'h7E, 8'h7D, 8'h03};
`endif
    foreach (pl[i]) write_byte(pl[i]);
    do_send();
    wait_done(200, 1'b0, ok);
    total++; if (!ok) $display("FAIL esc_done_timeout: got no done expected done"); else passed++;
    total++; if (got.size() != exp.size()) $display("FAIL esc_len: got %0d expected %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) $display("FAIL esc_byte[%0d]: got %02h expected %02h", i, got[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    bq_t pl, exp;
    bit ok;
    int n0;
    got.delete();
    for (int i = 0; i < 4; i++) write_byte(8'h40 + 8'(i));
    do_send();
    for (int i = 0; i < 100; i++) begin
      if (got.size() >= 3) break;
      tick();
    end
    total++; if (got.size() < 3) $display("FAIL mrst_reach_data: got %0d bytes expected 3", got.size()); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (pl_full !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL mrst_outputs: got full=%b busy=%b done=%b err=%b start=%b data=%02h expected all 0",
               pl_full, busy, done, err, tx_start, tx_data);
    else passed++;
    n0 = got.size();
    for (int i = 0; i < 10; i++) tick();
    total++; if (got.size() != n0) $display("FAIL mrst_no_more_tx: got %0d extra bytes expected 0", got.size() - n0); else passed++;
    got.delete();
    pl = '{8'h11};
    exp = build_frame(pl);
    write_byte(8'h11);
    do_send();
    wait_done(200, 1'b0, ok);
    total++; if (!ok) $display("FAIL mrst_done_timeout: got no done expected done"); else passed++;
    total++; if (got.size() != 4 || exp[3] !== 8'hEE) $display("FAIL mrst_len: got %0d expected 4", got.size()); else passed++;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) $display("FAIL mrst_byte[%0d]: got %02h expected %02h", i, got[i], exp[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    bq_t pl, exp;
    bit ok;
    int n;
    for (int f = 0; f < 6; f++) begin
      got.delete();
      pl.delete();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) pl.push_back($urandom_range(0, 1) ? 8'h7E : 8'h7D);
        else pl.push_back(8'($urandom));
      end
      exp = build_frame(pl);
      for (int i = 0; i < n - 1; i++) write_byte(pl[i]);
      // Last byte written in the same cycle as send must join the frame.
      pl_wr = 1'b1; pl_data = pl[n-1]; send = 1'b1;
      tick();
      pl_wr = 1'b0; send = 1'b0;
      wait_done(600, 1'b1, ok);
      total++; if (!ok) $display("FAIL rnd%0d_done_timeout: got no done expected done", f); else passed++;
      total++; if (got.size() != exp.size()) $display("FAIL rnd%0d_len: got %0d expected %0d", f, got.size(), exp.size()); else passed++;
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        total++;
        if (got[i] !== exp[i]) $display("FAIL rnd%0d_byte[%0d]: got %02h expected %02h", f, i, got[i], exp[i]);
        else passed++;
      end
    end
    total++; if (viol != 0) $display("FAIL rnd_issue_rule: got %0d violations expected 0", viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_overflow();
    test_escape();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
